// File: rtl/seq_add_acc_pkg.sv
// Shared definitions for the sequential adder/accumulator: operation modes
// and the channel-select width helper.
package seq_add_acc_pkg;

   typedef enum logic [1:0] {
      MODE_SUM      = 2'b00,
      MODE_ACC_WRAP = 2'b01,
      MODE_ACC_SAT  = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   localparam int MAX_CHANNELS = 8;

   // A single-channel build still carries a 1-bit select so the port never vanishes.
   function automatic int ch_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/seq_add_acc_acc_channel.sv
// One accumulator with its sticky overflow flag; wraps or saturates on carry-out
// depending on the mode, and exposes the candidate next value for the result path.
module acc_channel
   import seq_add_acc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_en,
   input  logic              i_clr,
   input  mode_e             i_mode,
   input  logic [DATA_W:0]   i_addend,
   output logic [ACC_W-1:0]  o_acc,
   output logic [ACC_W-1:0]  o_acc_next,
   output logic              o_ovf
);

   logic [ACC_W-1:0] r_acc;
   logic             r_ovf;
   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic             w_accum;

   always_comb begin
      w_sum      = {1'b0, r_acc} + {{(ACC_W-DATA_W){1'b0}}, i_addend};
      w_carry    = w_sum[ACC_W];
      w_accum    = 1'b0;
      o_acc_next = r_acc;
      case (i_mode)
         MODE_ACC_WRAP: begin
            w_accum    = 1'b1;
            o_acc_next = w_sum[ACC_W-1:0];
         end
         MODE_ACC_SAT: begin
            w_accum    = 1'b1;
            o_acc_next = w_carry ? '1 : w_sum[ACC_W-1:0];
         end
         default: ;
      endcase
   end

   // Clear has priority over an accumulate in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (i_clr) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (i_en && w_accum) begin
         r_acc <= o_acc_next;
         if (w_carry) r_ovf <= 1'b1;
      end
   end

   assign o_acc = r_acc;
   assign o_ovf = r_ovf;

endmodule

// File: rtl/tt_um_seq_add_acc.sv
// Tiny Tapeout wrapper: continuous SUM of ui_in and uio_in on channel 0;
// status bits are placed on uio_out but the bidirectional pins stay inputs.
module tt_um_seq_add_acc
   import seq_add_acc_pkg::*;
(
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   logic w_out_valid;
   logic w_ovf;

   seq_add_acc #(
      .DATA_W   (8),
      .ACC_W    (16),
      .CHANNELS (2)
   ) u_core (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .a_in       (ui_in),
      .b_in       (uio_in),
      .in_valid   (1'b1),
      .mode       (MODE_SUM),
      .ch_sel     (1'b0),
      .clr        (1'b0),
      .hi_sel     (1'b0),
      .result_out (uo_out),
      .out_valid  (w_out_valid),
      .ovf        (w_ovf)
   );

   assign uio_out = {6'b0, w_ovf, w_out_valid};
   assign uio_oe  = 8'h00;

endmodule

// File: rtl/seq_add_acc.sv
// Sequential adder with CHANNELS independent accumulators; one-cycle latency
// from an accepted operation to result_out/out_valid.
module seq_add_acc
   import seq_add_acc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ACC_W    = 16,
   parameter int CHANNELS = 2
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic [DATA_W-1:0]              a_in,
   input  logic [DATA_W-1:0]              b_in,
   input  logic                           in_valid,
   input  logic [1:0]                     mode,
   input  logic [ch_width(CHANNELS)-1:0]  ch_sel,
   input  logic                           clr,
   input  logic                           hi_sel,
   output logic [DATA_W-1:0]              result_out,
   output logic                           out_valid,
   output logic                           ovf
);

   localparam int CH_W  = ch_width(CHANNELS);
   localparam int RES_W = 2 * DATA_W;

   mode_e               w_mode;
   logic [DATA_W:0]     w_sum_ab;
   logic [CHANNELS-1:0] w_ch_hit;
   logic                w_ch_ok;
   logic                w_op;
   logic                w_clr_go;
   logic [ACC_W-1:0]    w_acc      [CHANNELS];
   logic [ACC_W-1:0]    w_acc_next [CHANNELS];
   logic [CHANNELS-1:0] w_ovf;
   logic [ACC_W-1:0]    w_sel_acc;
   logic [ACC_W-1:0]    w_sel_next;
   logic                w_last_ovf;
   logic [RES_W-1:0]    w_res_next;

   logic [RES_W-1:0]    r_result;
   logic                r_hi_sel;
   logic                r_out_valid;
   logic [CH_W-1:0]     r_last_ch;

   function automatic logic [RES_W-1:0] widen_acc(input logic [ACC_W-1:0] v);
      logic [RES_W-1:0] r;
      r            = '0;
      r[ACC_W-1:0] = v;
      return r;
   endfunction

   assign w_mode   = mode_e'(mode);
   assign w_sum_ab = {1'b0, a_in} + {1'b0, b_in};

   // Decode by comparison so out-of-range selects simply hit nothing.
   always_comb begin
      w_ch_hit   = '0;
      w_sel_acc  = '0;
      w_sel_next = '0;
      w_last_ovf = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (ch_sel == CH_W'(i)) begin
            w_ch_hit[i] = 1'b1;
            w_sel_acc   = w_acc[i];
            w_sel_next  = w_acc_next[i];
         end
         if (r_last_ch == CH_W'(i)) w_last_ovf = w_ovf[i];
      end
   end

   assign w_ch_ok  = |w_ch_hit;
   assign w_op     = ena & in_valid & w_ch_ok;
   assign w_clr_go = ena & clr & w_ch_ok;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      acc_channel #(
         .DATA_W (DATA_W),
         .ACC_W  (ACC_W)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_en       (w_op & w_ch_hit[g]),
         .i_clr      (w_clr_go & w_ch_hit[g]),
         .i_mode     (w_mode),
         .i_addend   (w_sum_ab),
         .o_acc      (w_acc[g]),
         .o_acc_next (w_acc_next[g]),
         .o_ovf      (w_ovf[g])
      );
   end

   always_comb begin
      w_res_next = '0;
      if (!clr) begin
         case (w_mode)
            MODE_SUM:  w_res_next[DATA_W:0] = w_sum_ab;
            MODE_HOLD: w_res_next = widen_acc(w_sel_acc);
            default:   w_res_next = widen_acc(w_sel_next);
         endcase
      end
   end

   // out_valid is refreshed even while ena is low so a stale pulse cannot linger.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_hi_sel    <= 1'b0;
         r_out_valid <= 1'b0;
         r_last_ch   <= '0;
      end else begin
         r_out_valid <= w_op;
         if (w_op) begin
            r_result <= w_res_next;
            r_hi_sel <= hi_sel;
         end
         if (w_op || w_clr_go) r_last_ch <= ch_sel;
      end
   end

   assign result_out = r_hi_sel ? r_result[RES_W-1:DATA_W] : r_result[DATA_W-1:0];
   assign out_valid  = r_out_valid;
   assign ovf        = w_last_ovf;

endmodule

// File: tb/tb_seq_add_acc.sv
// Bench for seq_add_acc: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a plain-arithmetic model.
module tb_seq_add_acc;
   import seq_add_acc_pkg::*;

   localparam int     DATA_W   = 8;
   localparam int     ACC_W    = 16;
   localparam int     CHANNELS = 3;
   localparam int     CH_W     = 2;
   localparam longint ACC_MAX  = (longint'(1) << ACC_W) - 1;

   logic              clk;
   logic              rst_n;
   logic              ena;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic              in_valid;
   logic [1:0]        mode;
   logic [CH_W-1:0]   ch_sel;
   logic              clr;
   logic              hi_sel;
   logic [DATA_W-1:0] result_out;
   logic              out_valid;
   logic              ovf;

   logic [7:0] tt_ui, tt_uio, tt_uo, tt_uio_out, tt_uio_oe;

   int checks   = 0;
   int failures = 0;

   longint m_acc [CHANNELS];
   bit     m_ovf [CHANNELS];
   longint m_res  = 0;
   bit     m_hi   = 0;
   bit     m_vld  = 0;
   int     m_last = 0;

   seq_add_acc #(
      .DATA_W   (DATA_W),
      .ACC_W    (ACC_W),
      .CHANNELS (CHANNELS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .a_in       (a_in),
      .b_in       (b_in),
      .in_valid   (in_valid),
      .mode       (mode),
      .ch_sel     (ch_sel),
      .clr        (clr),
      .hi_sel     (hi_sel),
      .result_out (result_out),
      .out_valid  (out_valid),
      .ovf        (ovf)
   );

   tt_um_seq_add_acc tt (
      .ui_in   (tt_ui),
      .uo_out  (tt_uo),
      .uio_in  (tt_uio),
      .uio_out (tt_uio_out),
      .uio_oe  (tt_uio_oe),
      .ena     (ena),
      .clk     (clk),
      .rst_n   (rst_n)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint exp_result();
      longint mask;
      mask = (longint'(1) << DATA_W) - 1;
      return m_hi ? ((m_res >> DATA_W) & mask) : (m_res & mask);
   endfunction

   // Reference model: the rules applied with integer arithmetic at each clock edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            m_acc[i] = 0;
            m_ovf[i] = 0;
         end
         m_res = 0; m_hi = 0; m_vld = 0; m_last = 0;
      end else begin : upd
         int     ch;
         longint s;
         ch    = int'(ch_sel);
         m_vld = 0;
         if (ena && ch < CHANNELS) begin
            m_vld = in_valid;
            if (clr) begin
               m_acc[ch] = 0;
               m_ovf[ch] = 0;
               if (in_valid) m_res = 0;
            end else if (in_valid) begin
               s = m_acc[ch] + longint'(a_in) + longint'(b_in);
               case (mode)
                  2'b00: m_res = longint'(a_in) + longint'(b_in);
                  2'b01: begin
                     if (s > ACC_MAX) begin s = s - (ACC_MAX + 1); m_ovf[ch] = 1; end
                     m_acc[ch] = s; m_res = s;
                  end
                  2'b10: begin
                     if (s > ACC_MAX) begin s = ACC_MAX; m_ovf[ch] = 1; end
                     m_acc[ch] = s; m_res = s;
                  end
                  default: m_res = m_acc[ch];
               endcase
            end
            if (in_valid) m_hi = hi_sel;
            if (in_valid || clr) m_last = ch;
         end
      end
   end

   always @(negedge clk) begin
      check("cmp_out_valid", longint'(out_valid), longint'(m_vld));
      check("cmp_result_out", longint'(result_out), exp_result());
      check("cmp_ovf", longint'(ovf), longint'(m_ovf[m_last]));
   end

   task automatic apply(input bit e, input bit v, input logic [1:0] md, input int ch,
                        input int a, input int b, input bit c, input bit h);
      ena = e; in_valid = v; mode = md; ch_sel = CH_W'(ch);
      a_in = DATA_W'(a); b_in = DATA_W'(b); clr = c; hi_sel = h;
      @(negedge clk); #1;
   endtask

   task automatic hold(input int ch, input bit h);
      apply(1, 1, 2'b11, ch, 0, 0, 0, h);
   endtask

   initial begin
      rst_n = 1'b1; ena = 0; in_valid = 0; mode = 0; ch_sel = 0;
      a_in = 0; b_in = 0; clr = 0; hi_sel = 0;
      tt_ui = 8'd200; tt_uio = 8'd100;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      check("rst_result_out", longint'(result_out), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_ovf", longint'(ovf), 0);
      check("rst_tt_uo", longint'(tt_uo), 0);
      rst_n = 1'b1;

      apply(1, 1, 2'b00, 0, 200, 100, 0, 0);
      check("sum_lo", longint'(result_out), 44);
      check("sum_vld", longint'(out_valid), 1);
      check("tt_sum", longint'(tt_uo), 44);
      tt_ui = 8'd17; tt_uio = 8'd3;
      apply(1, 1, 2'b00, 0, 200, 100, 0, 1);
      check("sum_hi", longint'(result_out), 1);
      check("tt_sum2", longint'(tt_uo), 20);
      check("tt_oe", longint'(tt_uio_oe), 0);
      apply(1, 0, 2'b00, 0, 0, 0, 0, 0);
      check("idle_vld", longint'(out_valid), 0);

      repeat (300) apply(1, 1, 2'b01, 0, 255, 0, 0, 0);
      hold(0, 0);
      check("wrap_lo", longint'(result_out), 212);
      check("wrap_ovf", longint'(ovf), 1);
      hold(0, 1);
      check("wrap_hi", longint'(result_out), 42);
      hold(1, 0);
      check("ch1_untouched", longint'(result_out), 0);
      check("ch1_ovf", longint'(ovf), 0);

      repeat (128) apply(1, 1, 2'b10, 1, 255, 255, 0, 0);
      apply(1, 1, 2'b10, 1, 220, 0, 0, 0);
      hold(1, 0);
      check("sat_pre_lo", longint'(result_out), 220);
      apply(1, 1, 2'b10, 1, 50, 0, 0, 0);
      check("sat_lo", longint'(result_out), 255);
      check("sat_ovf", longint'(ovf), 1);
      hold(1, 1);
      check("sat_hi", longint'(result_out), 255);

      apply(1, 0, 2'b00, 0, 0, 0, 1, 0);
      check("clr_novld", longint'(out_valid), 0);
      check("clr_ovf", longint'(ovf), 0);
      repeat (2) apply(1, 1, 2'b01, 0, 255, 245, 0, 0);
      hold(0, 0);
      check("acc1000_lo", longint'(result_out), 232);
      hold(0, 1);
      check("acc1000_hi", longint'(result_out), 3);
      apply(1, 1, 2'b01, 0, 5, 0, 1, 0);
      check("clrv_result", longint'(result_out), 0);
      check("clrv_vld", longint'(out_valid), 1);
      check("clrv_ovf", longint'(ovf), 0);
      hold(0, 0);
      check("clrv_acc", longint'(result_out), 0);

      for (int i = 0; i < 5; i++) begin
         apply(0, 1, 2'b01, 1, 7, 7, 0, 0);
         check("ena_low_vld", longint'(out_valid), 0);
      end
      hold(1, 0);
      check("ena_low_acc", longint'(result_out), 255);
      apply(1, 1, 2'b01, 3, 9, 9, 0, 0);
      check("badch_vld", longint'(out_valid), 0);
      apply(1, 1, 2'b01, 3, 9, 9, 1, 0);
      check("badch_clr_vld", longint'(out_valid), 0);

      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7,
               2'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      end

      apply(1, 1, 2'b00, 0, 200, 100, 0, 0);
      check("pre_rst_result", longint'(result_out), 44);
      check("pre_rst_vld", longint'(out_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      check("arst_result", longint'(result_out), 0);
      check("arst_vld", longint'(out_valid), 0);
      check("arst_ovf", longint'(ovf), 0);
      check("arst_tt", longint'(tt_uo), 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      hold(0, 0);
      check("post_rst_ch0", longint'(result_out), 0);
      check("post_rst_vld", longint'(out_valid), 1);
      hold(1, 1);
      check("post_rst_ch1", longint'(result_out), 0);
      apply(1, 0, 2'b00, 0, 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
